// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: memory-unit FSM
// encoding, primary opcodes and instruction-register field positions.
package mips_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   // Transaction captured in IDLE and replayed onto the bus during REQ.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        fetch;
   } mem_txn_t;

endpackage

// File: rtl/bus_watchdog.sv
// Bus watchdog: down-counter that flags a stuck bus transaction.
// Built only when MEM_TIMEOUT_EN is defined.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start       - pulse on entry to the request state (loads the counter)
//   active      - high while the request is outstanding
//   expire      - high in the TIMEOUT_CYCLES-th outstanding cycle
`ifdef MEM_TIMEOUT_EN
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic active,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (start) begin
         cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
      end else if (active && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign expire = active && (cnt_q == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/mem_unit.sv
// Memory interface unit for the multicycle MIPS core. Captures a read or
// write request from the control FSM, runs one external bus transaction,
// and steers read data into IR (fetch) or MDR.
// Optional build macro: MEM_TIMEOUT_EN adds a bus watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles without busAck and sets busErr.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   memRead, memWrite, iOrD, irWrite - request and steering from control
//   pc, aluOut, writeData          - fetch address, data address, store data
//   busReq, busWe, busAddr, busWdata - registered external bus request
//   busRdata, busAck               - external read data and completion
//   op, funct, rs, rt, rd, imm     - IR fields
//   mdr                            - memory data register
//   stall                          - transaction in flight
//   alignErr, busErr               - sticky error flags
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for memRead/memWrite; latches the transaction
// REQ     | busReq asserted, waiting for busAck (or watchdog expiry)
// DONE    | one-cycle completion, stall low, new requests ignored
module mem_unit
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        iOrD,
   input  logic        irWrite,
   input  logic [31:0] pc,
   input  logic [31:0] aluOut,
   input  logic [31:0] writeData,
   output logic        busReq,
   output logic        busWe,
   output logic [31:0] busAddr,
   output logic [31:0] busWdata,
   input  logic [31:0] busRdata,
   input  logic        busAck,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm,
   output logic [31:0] mdr,
   output logic        stall,
   output logic        alignErr,
   output logic        busErr
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_unit: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]  state_q, state_d;
   mem_txn_t    txn_q, txn_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] mdr_q, mdr_d;
   logic        align_err_q, align_err_d;
   logic        req_any;
   logic [31:0] addr_sel;

   assign req_any  = memRead | memWrite;
   assign addr_sel = iOrD ? aluOut : pc;

`ifdef MEM_TIMEOUT_EN
   logic bus_err_q, bus_err_d;
   logic wd_start, wd_active, wd_expire;

   assign wd_start  = (state_q == ST_IDLE) && (state_d == ST_REQ);
   assign wd_active = (state_q == ST_REQ);

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_bus_watchdog (
      .clk   (clk),
      .reset (reset),
      .start (wd_start),
      .active(wd_active),
      .expire(wd_expire)
   );
`endif

   always_comb begin
      state_d     = state_q;
      txn_d       = txn_q;
      ir_d        = ir_q;
      mdr_d       = mdr_q;
      align_err_d = align_err_q;
`ifdef MEM_TIMEOUT_EN
      bus_err_d   = bus_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               txn_d.addr  = addr_sel;
               txn_d.wdata = writeData;
               // A simultaneous read is dropped: the write wins.
               txn_d.we    = memWrite;
               txn_d.fetch = irWrite & ~memWrite;
               if (addr_sel[1:0] != 2'b00) begin
                  align_err_d = 1'b1;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (busAck) begin
               if (!txn_q.we) begin
                  if (txn_q.fetch) begin
                     ir_d = busRdata;
                  end else begin
                     mdr_d = busRdata;
                  end
               end
               state_d = ST_DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (wd_expire) begin
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Bus strobes are registered, so they follow the next state.
      bus_req_d = (state_d == ST_REQ);
      bus_we_d  = (state_d == ST_REQ) & txn_d.we;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         txn_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         ir_q        <= '0;
         mdr_q       <= '0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         txn_q       <= txn_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         ir_q        <= ir_d;
         mdr_q       <= mdr_d;
         align_err_q <= align_err_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= bus_err_d;
      end
   end
   assign busErr = bus_err_q;
`else
   assign busErr = 1'b0;
`endif

   assign busReq   = bus_req_q;
   assign busWe    = bus_we_q;
   assign busAddr  = txn_q.addr;
   assign busWdata = txn_q.wdata;

   assign stall = (state_q == ST_REQ) || ((state_q == ST_IDLE) && req_any);

   assign op       = ir_q[OP_MSB:OP_LSB];
   assign rs       = ir_q[RS_MSB:RS_LSB];
   assign rt       = ir_q[RT_MSB:RT_LSB];
   assign rd       = ir_q[RD_MSB:RD_LSB];
   assign imm      = ir_q[IMM_MSB:IMM_LSB];
   assign funct    = ir_q[FUNCT_MSB:FUNCT_LSB];
   assign mdr      = mdr_q;
   assign alignErr = align_err_q;

endmodule

// File: tb/tb_mem_unit.sv
module tb_mem_unit;
   import mips_pkg::*;

   localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite, iOrD, irWrite;
   logic [31:0] pc, aluOut, writeData;
   logic        busReq, busWe;
   logic [31:0] busAddr, busWdata;
   logic [31:0] busRdata;
   logic        busAck;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [31:0] mdr;
   logic        stall, alignErr, busErr;

   always #5 clk = ~clk;

   mem_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(rst),
      .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD), .irWrite(irWrite),
      .pc(pc), .aluOut(aluOut), .writeData(writeData),
      .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata),
      .busRdata(busRdata), .busAck(busAck),
      .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
      .mdr(mdr), .stall(stall), .alignErr(alignErr), .busErr(busErr)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endfunction

   // Reference model: architectural registers, sticky flags, memory image.
   typedef struct {
      logic [31:0] ir;
      logic [31:0] mdr;
      logic        align;
      logic        berr;
      int          nbus;
      int          nstall;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] model_mem[logic [31:0]];
   logic [31:0] resp_mem[logic [31:0]];
   logic [31:0] m_ir = '0, m_mdr = '0;
   logic        m_align = 1'b0, m_berr = 1'b0;

   function automatic logic [31:0] init_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Bus responder: acks after ack_wait wait cycles, optionally injects
   // stray acks while no request is outstanding.
   int ack_wait = 0;
   int wcnt     = 0;
   bit spur_en  = 1'b0;

   always @(negedge clk) begin
      busAck = 1'b0;
      if (rst || !busReq) begin
         wcnt = 0;
         if (!rst && spur_en && ($urandom_range(0, 3) == 0)) begin
            busAck   = 1'b1;
            busRdata = $urandom;
         end
      end else if (wcnt == ack_wait) begin
         busAck = 1'b1;
         if (busWe) begin
            resp_mem[busAddr] = busWdata;
         end else begin
            busRdata = resp_mem.exists(busAddr) ? resp_mem[busAddr] : init_word(busAddr);
         end
         wcnt = 0;
      end else begin
         wcnt++;
      end
   end

   // Monitor: a transaction ends when stall falls; pop and compare.
   bit          mon_en = 1'b0;
   bit          in_txn = 1'b0;
   int          n_stall = 0, n_bus = 0, n_unstable = 0;
   logic [31:0] c_addr, c_wdata;
   logic        c_we;

   always @(negedge clk) begin
      if (mon_en) begin
         if (stall) begin
            in_txn = 1'b1;
            n_stall++;
            if (busReq) begin
               n_bus++;
               if (n_bus == 1) begin
                  c_addr = busAddr; c_wdata = busWdata; c_we = busWe;
               end else if (busAddr !== c_addr || busWdata !== c_wdata || busWe !== c_we) begin
                  n_unstable++;
               end
            end
         end else begin
            if (busReq) chk("busreq_without_stall", 32'(busReq), 32'd0);
            if (in_txn) begin
               if (sb_q.size() == 0) begin
                  chk("sb_pending", 32'(sb_q.size()), 32'd1);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  chk("stall_cycles", 32'(n_stall), 32'(e.nstall));
                  chk("bus_cycles", 32'(n_bus), 32'(e.nbus));
                  chk("ir", {op, rs, rt, imm}, e.ir);
                  chk("ir_rd", 32'(rd), 32'(e.ir[15:11]));
                  chk("ir_funct", 32'(funct), 32'(e.ir[5:0]));
                  chk("mdr", mdr, e.mdr);
                  chk("align_err", 32'(alignErr), 32'(e.align));
                  chk("bus_err", 32'(busErr), 32'(e.berr));
                  chk("bus_stable", 32'(n_unstable), 32'd0);
                  if (e.nbus > 0) begin
                     chk("bus_addr", c_addr, e.addr);
                     chk("bus_we", 32'(c_we), 32'(e.we));
                     if (e.we) chk("bus_wdata", c_wdata, e.wdata);
                  end
               end
               in_txn = 1'b0; n_stall = 0; n_bus = 0; n_unstable = 0;
            end
         end
      end
   end

   task automatic issue(input bit rdq, input bit wrq, input bit iord, input bit irw,
                        input logic [31:0] pcv, input logic [31:0] aluv,
                        input logic [31:0] wdv, input int waits, input bit hold);
      exp_t        e;
      logic [31:0] a, d;
      int          k;
      a = iord ? aluv : pcv;
      e.addr = a; e.we = wrq; e.wdata = wdv;
      if (a[1:0] != 2'b00) begin
         m_align = 1'b1; e.nbus = 0; e.nstall = 1;
      end else if (TO_EN && waits >= TO) begin
         m_berr = 1'b1; e.nbus = TO; e.nstall = TO + 1;
      end else begin
         e.nbus = waits + 1; e.nstall = waits + 2;
         if (wrq) begin
            model_mem[a] = wdv;
         end else begin
            d = model_mem.exists(a) ? model_mem[a] : init_word(a);
            if (irw) m_ir = d; else m_mdr = d;
         end
      end
      e.ir = m_ir; e.mdr = m_mdr; e.align = m_align; e.berr = m_berr;
      sb_q.push_back(e);

      memRead = rdq; memWrite = wrq; iOrD = iord; irWrite = irw;
      pc = pcv; aluOut = aluv; writeData = wdv; ack_wait = waits;
      @(posedge clk); #1;
      if (!hold) begin memRead = 1'b0; memWrite = 1'b0; end
      pc = $urandom; aluOut = $urandom; writeData = $urandom;
      iOrD = 1'($urandom); irWrite = 1'($urandom);
      k = 0;
      do begin
         @(negedge clk); k++;
      end while (stall && k < 200);
      if (stall) chk("txn_timeout", 32'(stall), 32'd0);
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'h200 + (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int sel;
      rst = 1'b1;
      memRead = 0; memWrite = 0; iOrD = 0; irWrite = 0;
      pc = '0; aluOut = '0; writeData = '0; busRdata = '0; busAck = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busreq", 32'(busReq), 32'd0);
      chk("rst_buswe", 32'(busWe), 32'd0);
      chk("rst_busaddr", busAddr, 32'd0);
      chk("rst_buswdata", busWdata, 32'd0);
      chk("rst_ir", {op, rs, rt, imm}, 32'd0);
      chk("rst_mdr", mdr, 32'd0);
      chk("rst_align", 32'(alignErr), 32'd0);
      chk("rst_buserr", 32'(busErr), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // Zero-wait instruction fetch of lw $2,4($1).
      resp_mem[32'h40]  = 32'h8C22_0004;
      model_mem[32'h40] = 32'h8C22_0004;
      issue(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 0, 0);
      chk("fetch_op", 32'(op), 32'(OP_LW));
      chk("fetch_rt", 32'(rt), 32'd2);
      chk("fetch_imm", 32'(imm), 32'h4);

      // Store with three wait states, then read it back into MDR.
      issue(0, 1, 1, 0, 32'h0, 32'h100, 32'hDEAD_BEEF, 3, 0);
      issue(1, 0, 1, 0, 32'h0, 32'h100, 32'h0, 1, 0);
      chk("readback_mdr", mdr, 32'hDEAD_BEEF);

      // Misaligned data access.
      issue(1, 0, 1, 0, 32'h0, 32'h102, 32'h0, 0, 0);
      chk("misaligned_flag", 32'(alignErr), 32'd1);

      // Randomised traffic with stray acks and requests held through DONE.
      spur_en = 1'b1;
      repeat (80) begin
         sel = $urandom_range(0, 2);
         issue(sel != 1, sel != 0, 1'($urandom), 1'($urandom), rand_addr(), rand_addr(),
               $urandom, $urandom_range(0, 3), 1'($urandom));
      end
      spur_en = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // Ack on the expiry cycle completes normally; no ack times out.
      issue(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, TO - 1, 0);
      chk("ack_wins_op", 32'(op), 32'(OP_LW));
      issue(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 1000, 0);
      chk("timeout_buserr", 32'(busErr), 32'd1);
`endif

      // Reset in the middle of a request after two wait cycles.
      mon_en = 1'b0;
      memRead = 1'b1; iOrD = 1'b0; irWrite = 1'b1; pc = 32'h80; ack_wait = 1000;
      @(posedge clk); #1;
      memRead = 1'b0;
      @(negedge clk);
      chk("midreq_busreq_w1", 32'(busReq), 32'd1);
      @(negedge clk);
      chk("midreq_busreq_w2", 32'(busReq), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midreq_rst_busreq", 32'(busReq), 32'd0);
      chk("midreq_rst_ir", {op, rs, rt, imm}, 32'd0);
      chk("midreq_rst_mdr", mdr, 32'd0);
      chk("midreq_rst_align", 32'(alignErr), 32'd0);
      chk("midreq_rst_buserr", 32'(busErr), 32'd0);
      chk("midreq_rst_stall", 32'(stall), 32'd0);
      chk("midreq_rst_busaddr", busAddr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_ir = '0; m_mdr = '0; m_align = 1'b0; m_berr = 1'b0; ack_wait = 0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      repeat (10) begin
         sel = $urandom_range(0, 2);
         issue(sel != 1, sel != 0, 1'($urandom), 1'($urandom), rand_addr(), rand_addr(),
               $urandom, $urandom_range(0, 3), 1'($urandom));
      end

      repeat (3) @(posedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
